// File: rtl/reg_pkg.sv
// Shared defaults and types for the register-hazard scoreboard.
package reg_pkg;

  localparam int SB_ADDR_W   = 4;
  localparam int SB_CNT_W    = 2;
  localparam int SB_NUM_REGS = 1 << SB_ADDR_W;

  typedef logic [SB_ADDR_W-1:0] reg_addr_t;
  typedef logic [SB_CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback <-> scoreboard signal bundle; master is the pipeline side.
interface reg_scoreboard_if
  import reg_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W
) ();

  localparam int NUM_REGS = 1 << ADDR_W;

  logic                flush;
  logic                iss_valid;
  logic [ADDR_W-1:0]   iss_addr;
  logic                iss_ready;
  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_addr;
  logic [ADDR_W-1:0]   rs_addr;
  logic [ADDR_W-1:0]   rt_addr;
  logic                stall;
  logic [NUM_REGS-1:0] busy;
  logic                err;

  modport master (
    output flush, iss_valid, iss_addr, wb_valid, wb_addr, rs_addr, rt_addr,
    input  iss_ready, stall, busy, err
  );

  modport slave (
    input  flush, iss_valid, iss_addr, wb_valid, wb_addr, rs_addr, rt_addr,
    output iss_ready, stall, busy, err
  );

endinterface

// File: rtl/decoder_onehot.sv
// Combinational IN_W -> 2**IN_W one-hot decoder with enable.
module decoder_onehot #(
  parameter int IN_W = 4
) (
  input  logic                   en_i,
  input  logic [IN_W-1:0]        in_i,
  output logic [(1<<IN_W)-1:0]   out_o
);

  always_comb begin
    // NOTE: default assignment first so no path leaves out_o unassigned (no latch).
    out_o = '0;
    if (en_i) out_o[in_i] = 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: saturating pending-write counter per register.
// Optional macro SB_ZERO_REG_HARDWIRE_EN treats register 0 as hardwired $zero.
module reg_scoreboard
  import reg_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int CNT_W  = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);

  localparam int               NUM_REGS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] inc_oh, dec_oh, busy;
  logic                iss_ready, iss_en, wb_en, same_reg;

  // A same-register issue+writeback nets to zero, so it is let through even
  // when the target is saturated and iss_ready reads low.
  always_comb begin
    same_reg = sb.iss_valid && sb.wb_valid && (sb.iss_addr == sb.wb_addr);
`ifdef SB_ZERO_REG_HARDWIRE_EN
    iss_ready = (sb.iss_addr == '0) || (cnt_q[sb.iss_addr] != CNT_MAX);
    iss_en    = sb.iss_valid && (iss_ready || same_reg) && (sb.iss_addr != '0) && !sb.flush;
    wb_en     = sb.wb_valid && (sb.wb_addr != '0) && !sb.flush;
`else
    iss_ready = (cnt_q[sb.iss_addr] != CNT_MAX);
    iss_en    = sb.iss_valid && (iss_ready || same_reg) && !sb.flush;
    wb_en     = sb.wb_valid && !sb.flush;
`endif
  end

  decoder_onehot #(.IN_W(ADDR_W)) u_iss_dec (
    .en_i  (iss_en),
    .in_i  (sb.iss_addr),
    .out_o (inc_oh)
  );

  decoder_onehot #(.IN_W(ADDR_W)) u_wb_dec (
    .en_i  (wb_en),
    .in_i  (sb.wb_addr),
    .out_o (dec_oh)
  );

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sb.flush) begin
        cnt_d[i] = '0;
      end else begin
        case ({inc_oh[i], dec_oh[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
          2'b01: begin
            if (cnt_q[i] == '0) err_d    = 1'b1;
            else                cnt_d[i] = cnt_q[i] - 1'b1;
          end
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
`ifdef SB_ZERO_REG_HARDWIRE_EN
    cnt_d[0] = '0;
`endif
  end

  // NOTE: the counter array is explicitly reset; hazard state must never wake up as X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every counter updates from the same pre-edge snapshot.
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) busy[i] = (cnt_q[i] != '0);
  end

  assign sb.busy      = busy;
  assign sb.stall     = busy[sb.rs_addr] | busy[sb.rt_addr];
  assign sb.iss_ready = iss_ready;
  assign sb.err       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: per-cycle model comparison plus directed literals.
module tb_reg_scoreboard;
  import reg_pkg::*;

  localparam int AW   = 4;
  localparam int CW   = 2;
  localparam int NR   = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.ADDR_W(AW)) sb_if ();

  reg_scoreboard #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model state: pending count per register and sticky error.
  int m_cnt [NR];
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_zero_reg(input int a);
`ifdef SB_ZERO_REG_HARDWIRE_EN
    return a == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ready(input int a);
    return is_zero_reg(a) || (m_cnt[a] != CMAX);
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] b;
    for (int i = 0; i < NR; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int nxt [NR];
    int ia, wa;
    bit ie, we;
    if (rst) begin
      for (int i = 0; i < NR; i++) m_cnt[i] <= 0;
      m_err <= 1'b0;
    end else begin
      nxt = m_cnt;
      ia  = int'(sb_if.iss_addr);
      wa  = int'(sb_if.wb_addr);
      if (!sb_if.flush && !(sb_if.iss_valid && sb_if.wb_valid && ia == wa)) begin
        ie = sb_if.iss_valid && exp_ready(ia) && !is_zero_reg(ia);
        we = sb_if.wb_valid && !is_zero_reg(wa);
        if (ie) nxt[ia] = nxt[ia] + 1;
        if (we) begin
          if (m_cnt[wa] == 0) m_err <= 1'b1;
          else                nxt[wa] = nxt[wa] - 1;
        end
      end
      m_cnt <= nxt;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",  sb_if.busy, exp_busy());
      check("stall", sb_if.stall,
            (m_cnt[sb_if.rs_addr] != 0) || (m_cnt[sb_if.rt_addr] != 0));
      check("iss_ready", sb_if.iss_ready, exp_ready(int'(sb_if.iss_addr)));
      check("err",   sb_if.err, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.flush     = 1'b0;
    sb_if.iss_valid = 1'b0;
    sb_if.wb_valid  = 1'b0;
  endtask

  initial begin
    reg_addr_t a0;
    a0 = '0;
    idle();
    sb_if.iss_addr = a0;
    sb_if.wb_addr  = a0;
    sb_if.rs_addr  = a0;
    sb_if.rt_addr  = a0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    check("rst_busy",  sb_if.busy, 0);
    check("rst_stall", sb_if.stall, 0);
    check("rst_ready", sb_if.iss_ready, 1);
    check("rst_err",   sb_if.err, 0);

    // Three issues to reg 5, then asynchronous reset mid-cycle.
    sb_if.iss_valid = 1'b1;
    sb_if.iss_addr  = 4'd5;
    repeat (3) step();
    sb_if.iss_valid = 1'b0;
    #1;
    check("r5_busy",  sb_if.busy, 16'h0020);
    check("r5_ready", sb_if.iss_ready, 0);
    check("r5_model", m_cnt[5], 3);
    #1 rst = 1'b1;
    #1;
    check("async_busy",  sb_if.busy, 0);
    check("async_err",   sb_if.err, 0);
    check("async_ready", sb_if.iss_ready, 1);
    step();
    rst = 1'b0;

    // Issue reg 3, lookup stalls; writeback alongside an issue to reg 10.
    sb_if.iss_valid = 1'b1;
    sb_if.iss_addr  = 4'd3;
    step();
    sb_if.iss_valid = 1'b0;
    sb_if.rs_addr   = 4'd3;
    #1 check("r3_stall", sb_if.stall, 1);
    sb_if.iss_valid = 1'b1;
    sb_if.iss_addr  = 4'd10;
    sb_if.wb_valid  = 1'b1;
    sb_if.wb_addr   = 4'd3;
    #1 check("r3_wb_same_cycle_stall", sb_if.stall, 1);
    step();
    idle();
    #1;
    check("r3_cleared_stall", sb_if.stall, 0);
    check("r10_busy", sb_if.busy, 16'h0400);
    sb_if.rt_addr = 4'd10;
    #1 check("rt10_stall", sb_if.stall, 1);
    sb_if.wb_valid = 1'b1;
    sb_if.wb_addr  = 4'd10;
    step();
    idle();
    sb_if.rs_addr = a0;
    sb_if.rt_addr = a0;

    // Saturation of reg 7.
    sb_if.iss_valid = 1'b1;
    sb_if.iss_addr  = 4'd7;
    repeat (3) step();
    check("r7_sat_ready", sb_if.iss_ready, 0);
    check("r7_sat_busy",  sb_if.busy, 16'h0080);
    step();
    check("r7_fourth_model", m_cnt[7], 3);
    sb_if.wb_valid = 1'b1;
    sb_if.wb_addr  = 4'd7;
    step();
    check("r7_same_cycle_ready", sb_if.iss_ready, 0);
    check("r7_same_cycle_model", m_cnt[7], 3);
    sb_if.iss_valid = 1'b0;
    step();
    check("r7_after_wb_ready", sb_if.iss_ready, 1);
    repeat (2) step();
    idle();
    #1;
    check("r7_drained_busy", sb_if.busy, 0);
    check("r7_drained_err",  sb_if.err, 0);

    // Underflow on reg 9, sticky through flush.
    sb_if.wb_valid = 1'b1;
    sb_if.wb_addr  = 4'd9;
    step();
    idle();
    check("r9_err",  sb_if.err, 1);
    check("r9_busy", sb_if.busy, 0);
    sb_if.flush = 1'b1;
    step();
    idle();
    check("r9_err_after_flush", sb_if.err, 1);

    // Flush with a concurrent issue.
    sb_if.iss_valid = 1'b1;
    sb_if.iss_addr  = 4'd1;
    step();
    sb_if.iss_addr  = 4'd2;
    step();
    sb_if.iss_addr  = 4'd4;
    step();
    sb_if.iss_valid = 1'b0;
    #1 check("pre_flush_busy", sb_if.busy, 16'h0016);
    sb_if.flush     = 1'b1;
    sb_if.iss_valid = 1'b1;
    sb_if.iss_addr  = 4'd6;
    step();
    idle();
    sb_if.rs_addr = 4'd6;
    #1;
    check("flush_busy",  sb_if.busy, 0);
    check("flush_stall", sb_if.stall, 0);
    sb_if.rs_addr = a0;

    // Register 0 behaviour, starting from a clean error flag.
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_if.iss_valid = 1'b1;
    sb_if.iss_addr  = a0;
    step();
    idle();
    #1;
`ifdef SB_ZERO_REG_HARDWIRE_EN
    check("r0_stall", sb_if.stall, 0);
    check("r0_busy",  sb_if.busy, 0);
    check("r0_ready", sb_if.iss_ready, 1);
`else
    check("r0_stall", sb_if.stall, 1);
    check("r0_busy",  sb_if.busy, 16'h0001);
`endif
    sb_if.wb_valid = 1'b1;
    sb_if.wb_addr  = a0;
    step();
    check("r0_wb1_err", sb_if.err, 0);
    step();
    idle();
`ifdef SB_ZERO_REG_HARDWIRE_EN
    check("r0_wb2_err", sb_if.err, 0);
`else
    check("r0_wb2_err", sb_if.err, 1);
`endif

    step();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register-hazard scoreboard for the 16-bit MIPS pipeline. It generalises fixed one-hot address decoding to ADDR_W bits, keeping a saturating pending-write counter per architectural register. Decode issues a destination write here, and writeback retires it. Two source-register lookups produce the stall signal used by the decode stage.

## Interface
Parameters:
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
- CNT_W, 2, pending-counter width per register; max in-flight writes per register = 2**CNT_W - 1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- flush  in  1  synchronous clear of all counters; overrides issue and writeback
- iss_valid  in  1  decode requests to mark a destination pending
- iss_addr  in  ADDR_W  destination register of issuing instruction
- iss_ready  out  1  issue accepted this cycle if iss_valid is high
- wb_valid  in  1  writeback retires one pending write
- wb_addr  in  ADDR_W  register being written back
- rs_addr  in  ADDR_W  source lookup A
- rt_addr  in  ADDR_W  source lookup B
- stall  out  1  rs or rt has a nonzero pending count
- busy  out  NUM_REGS  one-hot-per-register flag, bit i set when counter i is nonzero
- err  out  1  sticky; a writeback hit a zero counter

## Operation
- Counter cnt[i], CNT_W bits, for each register i. All counters reset to 0.
- Issue fires when iss_valid && iss_ready. cnt[iss_addr] increments at the next edge.
- iss_ready = (cnt[iss_addr] != max). It is combinational from registered state, so a saturated register refuses further issues.
- Writeback with wb_valid decrements cnt[wb_addr] at the next edge.
- Writeback at count 0 leaves the count at 0 and sets err. err clears only on rst; flush does not clear it.
- Issue and writeback to the same register in the same cycle leave the count unchanged. This holds even at max, because iss_ready is evaluated on the pre-edge count and the net change is 0.
- Issue and writeback to different registers in the same cycle: both apply independently.
- flush: all counters go to 0 at the next edge; any issue or writeback that cycle is ignored.
- stall = busy[rs_addr] | busy[rt_addr], combinational.
- busy[i] = (cnt[i] != 0).
- Address decode uses a one-hot NUM_REGS-wide decode of iss_addr and wb_addr. Each counter sees its own inc/dec strobes.

## Timing
- Reset values: all cnt = 0, busy = 0, stall = 0, err = 0, iss_ready = 1.
- An asserted rst takes effect immediately, mid-operation included; in-flight counts are lost.
- Issue-to-busy latency: 1 cycle. busy/stall reflect the issue on the cycle after the accepting edge.
- Writeback-to-clear latency: 1 cycle. There is no same-cycle bypass; decode stalls for the cycle in which wb_valid is asserted.
- No internal pipelining; all outputs are valid every cycle.

## Configuration
- Macro SB_ZERO_REG_HARDWIRE_EN.
- Defined: register 0 is $zero.
  - Issue and writeback to address 0 are ignored; iss_ready is forced to 1 for address 0.
  - cnt[0] stays 0, busy[0] = 0, and source lookups of address 0 never stall.
  - A writeback to 0 never sets err.
- Undefined: register 0 is tracked like every other register.

## Structure
- Shared package reg_pkg holds:
  - the ADDR_W and CNT_W defaults
  - a derived NUM_REGS constant
  - a typedef for the register address
  - a typedef for the counter
- Sub-module decoder_onehot (parameter IN_W): combinational IN_W to 2**IN_W one-hot decoder with an enable input. It is instantiated twice, once for issue strobes and once for writeback strobes.
- Counter array and lookup muxes stay in reg_scoreboard.

## Test plan
- Reset: assert rst mid-run after 3 issues to reg 5 -> busy = 0, err = 0, iss_ready = 1 immediately.
- Issue reg 3, then next cycle rs_addr = 3 -> stall = 1. Writeback reg 3 -> stall still 1 that cycle, 0 the cycle after.
- Saturation, CNT_W = 2: issue reg 7 three times -> cnt = 3 and iss_ready = 0. Fourth iss_valid is ignored. Same-cycle issue+wb to reg 7 -> cnt stays 3.
- Underflow: writeback reg 9 with cnt 0 -> err = 1 and remains 1 through a later flush. cnt[9] stays 0.
- Flush: issue regs 1, 2, 4, then flush with concurrent iss_valid to reg 6 -> all busy = 0, reg 6 not pending.
- With SB_ZERO_REG_HARDWIRE_EN: issue reg 0 and set rs_addr = 0 -> stall = 0, busy[0] = 0. Writeback reg 0 -> err = 0.
